// File: rtl/alu_divider_if.sv
// Start/done handshake and operand/result bus for the sequential divider.
interface alu_divider_if #(
    parameter int WIDTH_A = 8,
    parameter int WIDTH_B = 4
);
    logic               start;
    logic [WIDTH_A-1:0] A;
    logic [WIDTH_B-1:0] B;
    logic [WIDTH_A-1:0] Q;
    logic [WIDTH_B-1:0] R;
    logic               ready;
    logic               done;
    logic               dbz;

    modport master (
        output start, A, B,
        input  Q, R, ready, done, dbz
    );

    modport slave (
        input  start, A, B,
        output Q, R, ready, done, dbz
    );
endinterface

// File: rtl/alu_divider.sv
// Unsigned restoring divider: WIDTH_A-bit dividend / WIDTH_B-bit divisor,
// one quotient bit per clock, start/done handshake, divide-by-zero flag.
module alu_divider #(
    parameter int WIDTH_A = 8,
    parameter int WIDTH_B = 4
) (
    input  logic          clk,
    input  logic          rst,
    alu_divider_if.slave  bus
);
    localparam int CW = (WIDTH_A > 1) ? $clog2(WIDTH_A) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, ZERO, DONE} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [WIDTH_A-1:0] dvd;     // working dividend, quotient bits shift in at the LSB
    logic [WIDTH_B-1:0] rem;     // partial remainder, always < divisor after restore
    logic [WIDTH_B-1:0] div;

    logic [WIDTH_A-1:0] q_r;
    logic [WIDTH_B-1:0] r_r;
    logic               ready_r;
    logic               done_r;
    logic               dbz_r;

    // The shifted remainder needs one extra bit before the compare; after the
    // conditional subtract it fits back in WIDTH_B bits, so only that is stored.
    logic [WIDTH_B:0]   shifted;
    logic [WIDTH_B-1:0] diff;
    logic               take;

    // One restoring step: shift in the next dividend bit, compare, subtract.
    always_comb begin
        shifted = {rem, dvd[WIDTH_A-1]};
        take    = (shifted >= {1'b0, div});
        diff    = take ? WIDTH_B'(shifted - {1'b0, div}) : shifted[WIDTH_B-1:0];
    end

    // Control FSM and datapath registers with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            q_r     <= '0;
            r_r     <= '0;
            done_r  <= 1'b0;
            dbz_r   <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        div     <= bus.B;
                        dvd     <= bus.A;
                        rem     <= '0;
                        cnt     <= CW'(WIDTH_A - 1);
                        dbz_r   <= 1'b0;
                        ready_r <= 1'b0;
                        state   <= (bus.B == '0) ? ZERO : BUSY;
                    end else begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    rem <= diff;
                    dvd <= {dvd[WIDTH_A-2:0], take};
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        q_r     <= {dvd[WIDTH_A-2:0], take};
                        r_r     <= diff;
                        done_r  <= 1'b1;
                        ready_r <= 1'b1;
                        state   <= DONE;
                    end
                end
                ZERO: begin
                    q_r     <= '1;
                    r_r     <= '0;
                    dbz_r   <= 1'b1;
                    done_r  <= 1'b1;
                    ready_r <= 1'b1;
                    state   <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Q     = q_r;
    assign bus.R     = r_r;
    assign bus.ready = ready_r;
    assign bus.done  = done_r;
    assign bus.dbz   = dbz_r;
endmodule
